tlv5618_rx: RTL
===============

TLV5618_RX -- requirements
Module: tlv5618_rx

Interface
REQ-001 SHALL have parameter SyncStages, default 2, synchronizer depth (2..4) applied identically to dac_cs_n, dac_sclk, dac_din.
REQ-002 SHALL have clk  input  1  system clock; serial inputs oversampled in this domain.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have dac_cs_n  input  1  frame select, active-low, from the DAC serial master.
REQ-005 SHALL have dac_sclk  input  1  serial clock; DIN sampled on its falling edge.
REQ-006 SHALL have dac_din  input  1  serial data, MSB first.
REQ-007 SHALL have word  output  16  last accepted frame.
REQ-008 SHALL have word_valid  output  1  one-clk pulse per accepted frame.
REQ-009 SHALL have dac_a, dac_b, buf_q  output  12 each  decoded DAC A, DAC B, double-buffer latch.
REQ-010 SHALL have spd  output  1  speed bit (D14) of last accepted frame.
REQ-011 SHALL have pwr  output  1  power-down bit (D13) of last accepted frame.
REQ-012 SHALL have frame_err  output  1  one-clk pulse when a frame ends with bit count not equal to 16.
REQ-013 SHALL have rsv_err  output  1  one-clk pulse when an accepted frame carries reserved code R1R0=11.

Function
REQ-014 SHALL synchronize all three inputs through SyncStages flops, then edge-detect on the synchronized signals only.
REQ-015 SHALL support sclk high and low phases each at least SyncStages+1 clk periods; faster sclk is out of scope.
REQ-016 SHALL implement FSM WAIT_IDLE -> IDLE -> SHIFT -> IDLE.
REQ-017 WAIT_IDLE (entered at reset): SHALL ignore all activity until synced cs_n is high, then go to IDLE, so a frame in progress at reset release is never joined mid-frame.
REQ-018 IDLE: synced cs_n falling SHALL clear the shift register and the 5-bit bit counter, then go to SHIFT.
REQ-019 SHIFT: each synced sclk falling edge SHALL shift synced din in at LSB and increment the counter, saturating at 17.
REQ-020 SHIFT: synced cs_n rising SHALL end the frame; count==16 -> accept, else -> frame_err pulse and discard; either way return to IDLE.
REQ-021 An sclk falling edge in the same clk cycle as cs_n rising SHALL be ignored.
REQ-022 Accept SHALL assert word_valid and update word, spd, pwr exactly 1 clk after the cycle the synced cs_n rise is detected.
REQ-023 Decode on accept, with R1=D15, R0=D12, data=D11..D0: 00 -> dac_b and buf_q <= data; 01 -> buf_q <= data; 10 -> dac_a <= data and dac_b <= old buf_q; 11 -> registers unchanged and rsv_err pulse.
REQ-024 Decode updates SHALL be visible in the same cycle word_valid is high.
REQ-025 Only decode code 11 SHALL suppress register updates; word, spd and pwr SHALL update for every accepted frame, including code 11.
REQ-026 A cs_n high pulse of any length SHALL be a complete frame boundary, with no minimum gap required.
REQ-027 Synced sclk edges while cs_n is high SHALL be ignored.

Reset
REQ-028 Asserting rst_n low SHALL asynchronously clear every output, the shift register, the counter and the synchronizers to 0, and force state WAIT_IDLE.
REQ-029 Reset mid-frame SHALL discard the partial frame with no word_valid or frame_err pulse.
REQ-030 The synchronizer flops for dac_cs_n SHALL reset to 1.

Structure
REQ-031 The shared package tlv5618_pkg SHALL hold: field positions (R1=15, SPD=14, PWR=13, R0=12, data 11:0), the four R1R0 code constants, FrameBits=16, and the FSM state encoding.
REQ-032 The synchronizer plus rise/fall detector SHALL be the sub-module sync_edge (parameter SyncStages; outputs level, rise, fall), instantiated three times.

Verification
REQ-033 Reset release, then frame 16'h0ABC (code 00) -> one word_valid; word=16'h0ABC; dac_b=buf_q=12'hABC; dac_a=0; spd=0; pwr=0.
REQ-034 Frame 16'h1123 (01), then frame 16'h8456 (10) -> after the second frame, dac_a=12'h456, dac_b=12'h123, buf_q=12'h123.
REQ-035 cs_n high after 15 sclk falls, then after 17 falls -> two frame_err pulses, no word_valid, all registers unchanged.
REQ-036 Frame 16'hF00F (11) -> word_valid and rsv_err in the same cycle; word=16'hF00F; spd=1; pwr=1; dac_a, dac_b, buf_q unchanged.
REQ-037 rst_n pulsed after 8 bits of a frame while cs_n stays low, and the master completes the frame -> no pulses and outputs remain 0; the next full frame 16'h0001 is accepted with dac_b=12'h001.
REQ-038 Loopback with the TLV5618 serial transmitter at DivCntMax=2, 256 back-to-back frames with address ramp 0..255 -> 256 word_valid pulses, each word matching the ROM value, zero errors.

Source files
------------

// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 serial frame receiver: frame field
// positions, R1R0 control codes and the receiver FSM encoding.
package tlv5618_pkg;

    localparam int FrameBits = 16;
    localparam int R1Pos     = 15;
    localparam int SpdPos    = 14;
    localparam int PwrPos    = 13;
    localparam int R0Pos     = 12;
    localparam int DataMsb   = 11;
    localparam int DataLsb   = 0;
    localparam int DataBits  = DataMsb - DataLsb + 1;

    // R1R0 control codes
    typedef enum logic [1:0] {
        CODE_B_BUF  = 2'b00,  // write DAC B and the double buffer
        CODE_BUF    = 2'b01,  // write the double buffer only
        CODE_A_XFER = 2'b10,  // write DAC A, transfer buffer to DAC B
        CODE_RSV    = 2'b11   // reserved
    } code_e;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_e;

    function automatic code_e frame_code(input logic [FrameBits-1:0] f);
        return code_e'({f[R1Pos], f[R0Pos]});
    endfunction

endpackage

// File: rtl/tlv5618_rx_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module sync_edge #(
    parameter int   SyncStages = 2,
    parameter logic ResetVal   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SyncStages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d};
            prev_q <= sync_q[SyncStages-1];
        end
    end

    assign level = sync_q[SyncStages-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tlv5618_rx.sv
// TLV5618 serial frame receiver: oversamples CS/SCLK/DIN, assembles 16-bit
// frames and decodes them into the DAC A / DAC B / double-buffer registers.
module tlv5618_rx
    import tlv5618_pkg::*;
#(
    parameter int SyncStages = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dac_cs_n,
    input  logic                dac_sclk,
    input  logic                dac_din,
    output logic [15:0]         word,
    output logic                word_valid,
    output logic [DataBits-1:0] dac_a,
    output logic [DataBits-1:0] dac_b,
    output logic [DataBits-1:0] buf_q,
    output logic                spd,
    output logic                pwr,
    output logic                frame_err,
    output logic                rsv_err
);

    localparam logic [4:0] FullCount    = 5'(FrameBits);
    localparam logic [4:0] MaxCount     = 5'(FrameBits + 1);
    localparam logic [2:0] SettleCycles = 3'(SyncStages + 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic din_level, din_rise, din_fall;
    logic unused_sync;

    sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .d(dac_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall));

    sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(dac_sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));

    sync_edge #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .d(dac_din),
        .level(din_level), .rise(din_rise), .fall(din_fall));

    assign unused_sync = ^{sclk_level, sclk_rise, din_rise, din_fall};

    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q;
    logic [FrameBits-1:0] shreg_q;
    logic [2:0]           settle_q;
    logic                 settled;
    logic                 do_clear, do_shift, do_accept, do_reject;

    // The cs_n synchronizer powers up high; hold off until the real input
    // has propagated so a frame already in progress is never joined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
        end else if (settle_q != SettleCycles) begin
            settle_q <= settle_q + 3'd1;
        end
    end

    assign settled = (settle_q == SettleCycles);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_d   = state_q;
        do_clear  = 1'b0;
        do_shift  = 1'b0;
        do_accept = 1'b0;
        do_reject = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: if (settled && cs_level) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cs_fall) begin
                    do_clear = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // frame end wins over a coincident sclk fall
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == FullCount) do_accept = 1'b1;
                    else                        do_reject = 1'b1;
                end else if (sclk_fall) begin
                    do_shift = 1'b1;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (do_clear) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (do_shift) begin
            shreg_q <= {shreg_q[FrameBits-2:0], din_level};
            if (bit_cnt_q != MaxCount) bit_cnt_q <= bit_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word       <= '0;
            word_valid <= 1'b0;
            dac_a      <= '0;
            dac_b      <= '0;
            buf_q      <= '0;
            spd        <= 1'b0;
            pwr        <= 1'b0;
            frame_err  <= 1'b0;
            rsv_err    <= 1'b0;
        end else begin
            word_valid <= do_accept;
            frame_err  <= do_reject;
            rsv_err    <= do_accept && (frame_code(shreg_q) == CODE_RSV);
            if (do_accept) begin
                word <= shreg_q;
                spd  <= shreg_q[SpdPos];
                pwr  <= shreg_q[PwrPos];
                case (frame_code(shreg_q))
                    CODE_B_BUF: begin
                        dac_b <= shreg_q[DataMsb:DataLsb];
                        buf_q <= shreg_q[DataMsb:DataLsb];
                    end
                    CODE_BUF: buf_q <= shreg_q[DataMsb:DataLsb];
                    CODE_A_XFER: begin
                        // NOTE: non-blocking, so dac_b takes buf_q as it was before this frame.
                        dac_a <= shreg_q[DataMsb:DataLsb];
                        dac_b <= buf_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
